// File: rtl/decoder_scan_if.sv
// Control/status bundle between a scan master and the decoder scan sequencer.
// The master drives the scan request and channel setup, the sequencer returns decoder drive and status.
interface decoder_scan_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
);
    localparam int N_CH = 2**SEL_W;

    logic               start;
    logic               stop;
    logic               mode;
    logic [N_CH-1:0]    ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic               en;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode, ch_mask, dwell,
        input  sel, en, busy, done
    );

    modport slave (
        input  start, stop, mode, ch_mask, dwell,
        output sel, en, busy, done
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 3-to-8 style decoder: walks the channels set in a latched
// mask, holding each for dwell+1 cycles, with an optional one-cycle en=0 gap between channels.
module decoder_scan_ctrl #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8,
    parameter bit GAP_EN  = 1'b1
) (
    input logic           clk,
    input logic           rst,
    decoder_scan_if.slave scan
);
    localparam int N_CH = 2**SEL_W;

    typedef enum logic [1:0] {IDLE, DWELL, GAP} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic               en_q;
    logic               busy_q;
    logic               done_q;
    logic [N_CH-1:0]    mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               mode_q;
    logic [DWELL_W-1:0] cnt;

    logic [SEL_W:0]     above;
    logic               have_next;
    logic [SEL_W-1:0]   nxt_sel;

    function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] m);
        lowest_set = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (m[k]) lowest_set = SEL_W'(k);
    endfunction

    // Returns {found, index} of the lowest set bit strictly above cur.
    function automatic logic [SEL_W:0] next_above(input logic [N_CH-1:0] m,
                                                  input logic [SEL_W-1:0] cur);
        next_above = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (m[k] && (k > int'(cur))) next_above = {1'b1, SEL_W'(k)};
    endfunction

    always_comb begin
        above     = next_above(mask_q, sel_q);
        have_next = above[SEL_W] | mode_q;
        nxt_sel   = above[SEL_W] ? above[SEL_W-1:0] : lowest_set(mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan.start && !scan.stop) begin
                        if (scan.ch_mask != '0) begin
                            mask_q  <= scan.ch_mask;
                            dwell_q <= scan.dwell;
                            mode_q  <= scan.mode;
                            sel_q   <= lowest_set(scan.ch_mask);
                            cnt     <= scan.dwell;
                            en_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            state   <= DWELL;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                DWELL: begin
                    if (scan.stop) begin
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else if (have_next) begin
                        // With the gap, sel moves while en is low so two outputs never overlap.
                        sel_q <= nxt_sel;
                        if (GAP_EN) begin
                            en_q  <= 1'b0;
                            state <= GAP;
                        end else begin
                            cnt <= dwell_q;
                        end
                    end else begin
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                GAP: begin
                    if (scan.stop) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        en_q  <= 1'b1;
                        cnt   <= dwell_q;
                        state <= DWELL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign scan.sel  = sel_q;
    assign scan.en   = en_q;
    assign scan.busy = busy_q;
    assign scan.done = done_q;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: directed scans push per-cycle expected
// decoder drive/status into queues that negedge monitors pop and compare.
module tb_decoder_scan_ctrl;
    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;

    typedef struct {
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       done;
        int         tc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t qa[$];
    exp_t qb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    decoder_scan_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) if_a ();
    decoder_scan_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) if_b ();

    decoder_scan_ctrl #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .GAP_EN(1'b1)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .scan (if_a)
    );

    decoder_scan_ctrl #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .GAP_EN(1'b0)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .scan (if_b)
    );

    task automatic check_out(input string name, input exp_t e, input logic [2:0] sel,
                             input logic en, input logic busy, input logic done);
        vectors++;
        if (sel !== e.sel || en !== e.en || busy !== e.busy || done !== e.done) begin
            miscompares++;
            $display("FAIL %s test%0d @%0t: got sel=%0d en=%b busy=%b done=%b, expected sel=%0d en=%b busy=%b done=%b",
                     name, e.tc, $time, sel, en, busy, done, e.sel, e.en, e.busy, e.done);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            check_out("dut_a", e, if_a.sel, if_a.en, if_a.busy, if_a.done);
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (qb.size() != 0) begin
            e = qb.pop_front();
            check_out("dut_b", e, if_b.sel, if_b.en, if_b.busy, if_b.done);
        end
    end

    task automatic push(input bit to_b, input int tc, input logic [2:0] sel, input logic en,
                        input logic busy, input logic done, input int n);
        exp_t e;
        e.sel = sel; e.en = en; e.busy = busy; e.done = done; e.tc = tc;
        for (int i = 0; i < n; i++) begin
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int tc);
        int budget;
        budget = 2000;
        while ((qa.size() != 0 || qb.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL drain test%0d: got %0d/%0d entries pending, expected 0/0", tc, qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        step();
    endtask

    task automatic drive(input bit to_b, input logic start, input logic stop, input logic mode,
                         input logic [7:0] mask, input logic [7:0] dwell);
        if (to_b) begin
            if_b.start = start; if_b.stop = stop; if_b.mode = mode;
            if_b.ch_mask = mask; if_b.dwell = dwell;
        end else begin
            if_a.start = start; if_a.stop = stop; if_a.mode = mode;
            if_a.ch_mask = mask; if_a.dwell = dwell;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        step(); step(); step();
        rst = 1'b0;

        // Test 1: single pass with gaps; c0 also checks the reset state of both DUTs.
        push(0, 1, 0, 0, 0, 0, 1);
        push(1, 1, 0, 0, 0, 0, 1);
        push(0, 1, 0, 1, 1, 0, 3);
        push(0, 1, 2, 0, 1, 0, 1);
        push(0, 1, 2, 1, 1, 0, 3);
        push(0, 1, 5, 0, 1, 0, 1);
        push(0, 1, 5, 1, 1, 0, 3);
        push(0, 1, 5, 0, 0, 1, 1);
        push(0, 1, 5, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 8'b0010_0101, 8'd2);
        step();
        if_a.start = 1'b0;
        drain(1);

        // Test 2: continuous 0/7 with dwell 0, stop issued during the gap at c10.
        push(0, 2, 5, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            push(0, 2, 0, 1, 1, 0, 1);
            push(0, 2, 7, 0, 1, 0, 1);
            push(0, 2, 7, 1, 1, 0, 1);
            push(0, 2, 0, 0, 1, 0, 1);
        end
        push(0, 2, 0, 1, 1, 0, 1);
        push(0, 2, 7, 0, 1, 0, 1);
        push(0, 2, 7, 0, 0, 0, 2);
        drive(0, 1, 0, 1, 8'b1000_0001, 8'd0);
        step();
        if_a.start = 1'b0;
        repeat (9) step();
        if_a.stop = 1'b1;
        step();
        if_a.stop = 1'b0;
        drain(2);

        // Test 3: empty mask gives a lone done pulse.
        push(0, 3, 7, 0, 0, 0, 1);
        push(0, 3, 7, 0, 0, 1, 1);
        push(0, 3, 7, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 8'h00, 8'd4);
        step();
        if_a.start = 1'b0;
        drain(3);

        // Test 4: setup changes and a start pulse mid-scan are ignored.
        push(0, 4, 7, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) push(0, 4, 3'(k), 0, 1, 0, 1);
            push(0, 4, 3'(k), 1, 1, 0, 2);
        end
        push(0, 4, 7, 0, 0, 1, 1);
        push(0, 4, 7, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 8'hFF, 8'd1);
        step();
        drive(0, 0, 0, 1, 8'h01, 8'd0);
        repeat (7) step();
        if_a.start = 1'b1;
        step();
        if_a.start = 1'b0;
        drain(4);

        // Test 5: reset during channel 3 dwell, then a fresh scan from the lowest bit.
        push(0, 5, 7, 0, 0, 0, 1);
        push(0, 5, 1, 1, 1, 0, 4);
        push(0, 5, 3, 0, 1, 0, 1);
        push(0, 5, 3, 1, 1, 0, 2);
        push(0, 5, 0, 0, 0, 0, 2);
        push(0, 5, 3, 1, 1, 0, 1);
        push(0, 5, 4, 0, 1, 0, 1);
        push(0, 5, 4, 1, 1, 0, 1);
        push(0, 5, 4, 0, 0, 1, 1);
        push(0, 5, 4, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 8'b0001_1010, 8'd3);
        step();
        if_a.start = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        drive(0, 1, 0, 0, 8'b0001_1000, 8'd0);
        step();
        if_a.start = 1'b0;
        drain(5);

        // Test 7: stop during a dwell, then start+stop together does nothing.
        push(0, 7, 4, 0, 0, 0, 1);
        push(0, 7, 2, 1, 1, 0, 3);
        push(0, 7, 2, 0, 0, 0, 2);
        drive(0, 1, 0, 1, 8'b0000_0100, 8'd5);
        step();
        if_a.start = 1'b0;
        step(); step();
        if_a.stop = 1'b1;
        step();
        if_a.stop = 1'b0;
        drain(7);
        push(0, 7, 2, 0, 0, 0, 3);
        drive(0, 1, 1, 0, 8'h0F, 8'd0);
        step();
        drive(0, 0, 0, 0, 8'h0F, 8'd0);
        drain(7);

        // Test 6: no-gap DUT, channels 1 and 2, then start+stop together.
        push(1, 6, 0, 0, 0, 0, 1);
        push(1, 6, 1, 1, 1, 0, 2);
        push(1, 6, 2, 1, 1, 0, 2);
        push(1, 6, 2, 0, 0, 1, 1);
        push(1, 6, 2, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 8'b0000_0110, 8'd1);
        step();
        if_b.start = 1'b0;
        drain(6);
        push(1, 6, 2, 0, 0, 0, 3);
        drive(1, 1, 1, 0, 8'b0000_0110, 8'd1);
        step();
        drive(1, 0, 0, 0, 8'b0000_0110, 8'd1);
        drain(6);

        // Test 8: maximum dwell on the no-gap DUT, 256 cycles per channel.
        push(1, 8, 2, 0, 0, 0, 1);
        push(1, 8, 0, 1, 1, 0, 256);
        push(1, 8, 7, 1, 1, 0, 256);
        push(1, 8, 7, 0, 0, 1, 1);
        push(1, 8, 7, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 8'b1000_0001, 8'd255);
        step();
        if_b.start = 1'b0;
        drain(8);

        // Test 9: no-gap continuous single channel keeps en high until stop.
        push(1, 9, 7, 0, 0, 0, 1);
        push(1, 9, 4, 1, 1, 0, 8);
        push(1, 9, 4, 0, 0, 0, 2);
        drive(1, 1, 0, 1, 8'b0001_0000, 8'd1);
        step();
        if_b.start = 1'b0;
        repeat (7) step();
        if_b.stop = 1'b1;
        step();
        if_b.stop = 1'b0;
        drain(9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
Scan sequencer that drives the {en, in[2:0]} inputs of the 3-to-8 decoder. It steps through the channels enabled in a channel mask, holding each for a programmable dwell time. An optional break-before-make gap keeps two decoder outputs from being active across a transition. It supports single-pass and continuous modes, with start/stop control and busy/done status.

Parameters:
SEL_W, 3, width of channel select; N_CH = 2**SEL_W channels
DWELL_W, 8, width of dwell count
GAP_EN, 1, 1 = insert one en=0 cycle between consecutive channels; 0 = no gap

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to begin a scan; acted on only in IDLE
stop  input  1  abort the scan; takes effect on the next edge
mode  input  1  0 = single pass, 1 = continuous; sampled at accepted start
ch_mask  input  N_CH  bit k=1 means channel k is scanned; sampled at accepted start
dwell  input  DWELL_W  en is held high for dwell+1 cycles per channel; sampled at accepted start
sel  output  SEL_W  channel index to the decoder's in[]
en  output  1  enable to the decoder
busy  output  1  high from the first DWELL cycle until the scan ends
done  output  1  one-cycle pulse when a single pass completes

Behaviour:
- All outputs are registered. Reset: state=IDLE, sel=0, en=0, busy=0, done=0, latched mask/dwell/mode cleared.
- States: IDLE, DWELL, GAP.
- IDLE:
  - start=1, stop=0, ch_mask!=0: latch mask/dwell/mode. Next cycle: DWELL, sel = lowest set bit, en=1, busy=1, dwell counter = dwell.
  - start=1, ch_mask==0: stay in IDLE; done=1 for one cycle; en and busy stay 0.
  - start=1 and stop=1 in the same cycle: stop wins; no scan starts and done is not asserted.
- DWELL:
  - en=1. The counter decrements each cycle.
  - When the counter is 0, find the next channel: the next set bit strictly above sel in the latched mask.
  - Next channel exists: if GAP_EN, go to GAP (sel=next, en=0, busy=1); otherwise stay in DWELL with sel=next, en=1, counter reloaded.
  - No higher bit, mode=1: wrap to the lowest set bit, with the same GAP_EN rule.
  - No higher bit, mode=0: go to IDLE; en=0, busy=0, done=1 for one cycle.
- GAP: exactly one cycle with en=0 and sel already set to the new channel. Then DWELL with en=1 and the counter reloaded.
- Continuous mode with a single set bit: GAP_EN=1 gives en high for dwell+1 cycles then low for 1 cycle, repeating. GAP_EN=0 holds en high continuously.
- stop=1 in DWELL or GAP: next cycle IDLE, en=0, busy=0, no done pulse.
- start while busy: ignored.
- Inputs changing mid-scan: ch_mask, dwell and mode changes have no effect until the next accepted start.
- sel holds its last value in IDLE.
- en is never high in the same cycle as a sel change (GAP_EN=1). With GAP_EN=0, sel and en update on the same edge.
- dwell=0 means one cycle per channel. dwell=2**DWELL_W-1 means 2**DWELL_W cycles per channel; the counter does not overflow.
- rst asserted mid-scan returns all state and outputs to their reset values on the next edge.
- done and busy are never high in the same cycle.

Test Plan:
1. GAP_EN=1, mode=0, ch_mask=8'b0010_0101, dwell=2, start at cycle 0 -> cycles 1-3 sel=0 en=1; cycle 4 sel=2 en=0; cycles 5-7 sel=2 en=1; cycle 8 sel=5 en=0; cycles 9-11 sel=5 en=1; cycle 12 en=0 busy=0 done=1; cycle 13 done=0.
2. mode=1, ch_mask=8'b1000_0001, dwell=0, GAP_EN=1 -> en pattern 1,0 repeating with sel sequence 0,7,0,7...; busy stays 1 and done never asserts. Stop at cycle 10 -> cycle 11 en=0 busy=0 done=0.
3. ch_mask=8'h00 with start -> done=1 for exactly one cycle; en and busy stay 0.
4. Start accepted with ch_mask=8'hFF; change ch_mask to 8'h01 and dwell to 0 on the next cycle -> all 8 channels are scanned with the original dwell. A start pulse asserted mid-scan is ignored.
5. rst asserted during the DWELL of channel 3 -> next edge en=0, sel=0, busy=0, done=0. A new start scans from the lowest set bit.
6. GAP_EN=0, mode=0, ch_mask=8'b0000_0110, dwell=1 -> en stays high for cycles 1-4 (sel=1 in cycles 1-2, sel=2 in cycles 3-4); done=1 at cycle 5. start and stop asserted together in IDLE -> no activity.
